// File: rtl/servo_pkg.sv
// Shared constants and arithmetic helpers for the slew-limited servo controller.
// Helpers work on 32-bit values so any instance width up to 31 bits fits without wrap.
package servo_pkg;

  localparam int FRAME_CYCLES = 1_000_000;
  localparam int MIN_WIDTH    = 50_000;
  localparam int MAX_WIDTH    = 100_000;
  localparam int STEP         = 500;
  localparam int W            = 20;
  localparam int CENTER       = (MIN_WIDTH + MAX_WIDTH) / 2;

  typedef enum logic [1:0] {
    SERVO_OFF,
    SERVO_HOLD,
    SERVO_RAMP
  } servo_state_e;

  function automatic servo_state_e servo_state(input logic en_q, input logic busy);
    if (!en_q)
      return SERVO_OFF;
    else if (busy)
      return SERVO_RAMP;
    else
      return SERVO_HOLD;
  endfunction

  function automatic logic [31:0] clamp_width(input logic [31:0] value,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    if (value < lo)
      return lo;
    else if (value > hi)
      return hi;
    else
      return value;
  endfunction

  // One extra bit on every sum so neither direction can wrap past the target.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
    logic [32:0] up_sum;
    logic [32:0] down_floor;
    up_sum     = {1'b0, cur} + {1'b0, step};
    down_floor = {1'b0, tgt} + {1'b0, step};
    if (cur < tgt)
      return (up_sum >= {1'b0, tgt}) ? tgt : up_sum[31:0];
    else if (cur > tgt)
      return ({1'b0, cur} >= down_floor) ? (cur - step) : tgt;
    else
      return cur;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// PWM frame counter: counts 0..FRAME_CYCLES-1 and flags the last cycle of each frame.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES,
  parameter int W            = servo_pkg::W
) (
  input  logic         clock_clk,
  input  logic         reset,
  output logic [W-1:0] frame_cnt,
  output logic         frame_wrap
);

  localparam logic [W-1:0] LAST_CNT = W'(FRAME_CYCLES - 1);

  assign frame_wrap = (frame_cnt == LAST_CNT);

  always_ff @(posedge clock_clk or posedge reset) begin
    if (reset)
      frame_cnt <= '0;
    else if (frame_wrap)
      frame_cnt <= '0;
    else
      frame_cnt <= frame_cnt + 1'b1;
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Slew-limited servo controller: clamps commanded widths, ramps the live width once per
// frame and drives a frame-aligned PWM pulse so width changes never cut a pulse short.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES,
  parameter int MIN_WIDTH    = servo_pkg::MIN_WIDTH,
  parameter int MAX_WIDTH    = servo_pkg::MAX_WIDTH,
  parameter int STEP         = servo_pkg::STEP,
  parameter int W            = servo_pkg::W
) (
  input  logic         clock_clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_width,
  input  logic         enable,
  output logic         pwm_out,
  output logic [W-1:0] cur_width,
  output logic         busy,
  output logic         err_range
);

  localparam logic [W-1:0] RESET_WIDTH = W'((MIN_WIDTH + MAX_WIDTH) / 2);

  logic [W-1:0] frame_cnt;
  logic         frame_wrap;
  logic [W-1:0] target;
  logic         en_q;

  logic         accept;
  logic [W-1:0] clamped;
  logic [W-1:0] tgt_eff;
  logic [W-1:0] width_next;
  logic [W-1:0] cnt_next;
  logic         en_next;
  logic         pwm_next;

  servo_frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .W            (W)
  ) u_frame_timer (
    .clock_clk  (clock_clk),
    .reset      (reset),
    .frame_cnt  (frame_cnt),
    .frame_wrap (frame_wrap)
  );

  // The PWM register is loaded from next-cycle counter/width/enable values so that
  // pwm_out lines up exactly with frame_cnt instead of lagging by a cycle.
  always_comb begin
    accept     = cmd_valid && cmd_ready;
    clamped    = W'(clamp_width(32'(cmd_width), 32'(MIN_WIDTH), 32'(MAX_WIDTH)));
    tgt_eff    = accept ? clamped : target;
    width_next = cur_width;
    en_next    = en_q;
    cnt_next   = frame_cnt + 1'b1;
    if (frame_wrap) begin
      width_next = W'(step_toward(32'(cur_width), 32'(tgt_eff), 32'(STEP)));
      en_next    = enable;
      cnt_next   = '0;
    end
    pwm_next = en_next && (cnt_next < width_next);
  end

  always_ff @(posedge clock_clk or posedge reset) begin
    if (reset) begin
      target    <= RESET_WIDTH;
      cur_width <= RESET_WIDTH;
      en_q      <= 1'b0;
      pwm_out   <= 1'b0;
      cmd_ready <= 1'b0;
      err_range <= 1'b0;
    end else begin
      cmd_ready <= 1'b1;
      err_range <= accept && (clamped != cmd_width);
      if (accept)
        target <= clamped;
      cur_width <= width_next;
      en_q      <= en_next;
      pwm_out   <= pwm_next;
    end
  end

  assign busy = (cur_width != target);

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Scoreboard bench for servo_ramp_ctrl with small frame parameters; expected frame
// widths and err_range responses are queued at stimulus time and consumed by a monitor.
module tb_servo_ramp_ctrl;

  localparam int FRAME = 100;

  typedef struct {
    int hi;
    int cur;
    bit busy;
  } frame_t;

  logic       clock_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_width = 8'd0;
  logic       enable    = 1'b1;
  logic       pwm_out;
  logic [7:0] cur_width;
  logic       busy;
  logic       err_range;

  int total = 0;
  int bad   = 0;

  int tb_cnt    = 0;
  int frame_idx = 0;

  frame_t frame_q[$];
  bit     err_q[$];

  int hi_cnt      = 0;
  bit start_hi    = 0;
  bit acc_pending = 0;

  servo_ramp_ctrl #(
    .FRAME_CYCLES (FRAME),
    .MIN_WIDTH    (10),
    .MAX_WIDTH    (30),
    .STEP         (4),
    .W            (8)
  ) dut (
    .clock_clk (clock_clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_width (cmd_width),
    .enable    (enable),
    .pwm_out   (pwm_out),
    .cur_width (cur_width),
    .busy      (busy),
    .err_range (err_range)
  );

  always #5 clock_clk = ~clock_clk;

  // Bench-side frame position, independent of the DUT counter.
  always @(posedge clock_clk or posedge reset) begin
    if (reset) begin
      tb_cnt    <= 0;
      frame_idx <= 0;
    end else if (tb_cnt == FRAME - 1) begin
      tb_cnt    <= 0;
      frame_idx <= frame_idx + 1;
    end else begin
      tb_cnt <= tb_cnt + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: pops an err expectation the cycle after each accept and a frame record
  // at the last cycle of each frame.
  always @(negedge clock_clk) begin
    frame_t f;
    bit     e;
    if (reset) begin
      hi_cnt      = 0;
      start_hi    = 0;
      acc_pending = 0;
    end else begin
      if (acc_pending) begin
        if (err_q.size() > 0) begin
          e = err_q.pop_front();
          checkOutput("err_range", int'(err_range), int'(e));
        end else begin
          total++;
          bad++;
          $display("[TB] FAIL err_queue accept seen with no expectation queued");
        end
        acc_pending = 0;
      end else if (err_range) begin
        total++;
        bad++;
        $display("[TB] FAIL err_range_spurious actual=1 expected=0");
      end
      if (cmd_valid && cmd_ready)
        acc_pending = 1;
      if (tb_cnt == 0) begin
        hi_cnt   = 0;
        start_hi = pwm_out;
      end
      if (pwm_out)
        hi_cnt++;
      if (tb_cnt == FRAME - 1 && frame_q.size() > 0) begin
        f = frame_q.pop_front();
        checkOutput($sformatf("frame%0d_high_cycles", frame_idx), hi_cnt, f.hi);
        checkOutput($sformatf("frame%0d_starts_at_0", frame_idx), int'(start_hi), int'(f.hi > 0));
        checkOutput($sformatf("frame%0d_cur_width", frame_idx), int'(cur_width), f.cur);
        checkOutput($sformatf("frame%0d_busy", frame_idx), int'(busy), int'(f.busy));
      end
    end
  end

  task automatic expectFrame(input int hi, input int cur, input bit bsy);
    frame_t f;
    f.hi   = hi;
    f.cur  = cur;
    f.busy = bsy;
    frame_q.push_back(f);
  endtask

  task automatic doReset();
    @(posedge clock_clk);
    #1;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    enable    = 1'b1;
    frame_q.delete();
    err_q.delete();
    repeat (3) @(posedge clock_clk);
    #1;
    checkOutput("reset_pwm_out", int'(pwm_out), 0);
    checkOutput("reset_cmd_ready", int'(cmd_ready), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_err_range", int'(err_range), 0);
    checkOutput("reset_cur_width", int'(cur_width), 20);
    reset = 1'b0;
    @(posedge clock_clk);
    #1;
    checkOutput("ready_after_reset", int'(cmd_ready), 1);
  endtask

  task automatic waitAt(input int frame, input int pos, output bit ok);
    int guard = 0;
    while (!(frame_idx == frame && tb_cnt == pos) && guard < 5000) begin
      @(posedge clock_clk);
      #1;
      guard++;
    end
    ok = (guard < 5000);
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_timeout frame=%0d pos=%0d", frame, pos);
    end
  endtask

  task automatic applyStimulus(input int frame, input int pos, input logic [7:0] width,
                               input bit exp_err);
    bit ok;
    waitAt(frame, pos, ok);
    if (ok) begin
      err_q.push_back(exp_err);
      cmd_valid = 1'b1;
      cmd_width = width;
      @(posedge clock_clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((frame_q.size() > 0 || err_q.size() > 0) && guard < 2000) begin
      @(posedge clock_clk);
      guard++;
    end
    if (guard >= 2000) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout frames_left=%0d errs_left=%0d",
               frame_q.size(), err_q.size());
    end
    @(posedge clock_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;

    $display("[TB] hold at centre with no command");
    doReset();
    expectFrame(0, 20, 0);
    expectFrame(20, 20, 0);
    expectFrame(20, 20, 0);
    waitDrain();

    $display("[TB] ramp up to 30");
    doReset();
    expectFrame(0, 20, 0);
    expectFrame(20, 20, 1);
    expectFrame(24, 24, 1);
    expectFrame(28, 28, 1);
    expectFrame(30, 30, 0);
    expectFrame(30, 30, 0);
    applyStimulus(1, 50, 8'd30, 1'b0);
    waitDrain();

    $display("[TB] clamping of out-of-range commands");
    doReset();
    expectFrame(0, 20, 0);
    expectFrame(20, 20, 1);
    expectFrame(16, 16, 1);
    expectFrame(12, 12, 1);
    expectFrame(10, 10, 0);
    applyStimulus(1, 10, 8'd255, 1'b1);
    applyStimulus(1, 20, 8'd200, 1'b1);
    applyStimulus(1, 30, 8'd3, 1'b1);
    applyStimulus(4, 30, 8'd0, 1'b1);
    applyStimulus(4, 40, 8'd10, 1'b0);
    waitDrain();

    $display("[TB] later command in the same frame overwrites");
    doReset();
    expectFrame(0, 20, 0);
    expectFrame(20, 20, 1);
    expectFrame(16, 16, 1);
    expectFrame(12, 12, 0);
    expectFrame(12, 12, 0);
    applyStimulus(1, 20, 8'd30, 1'b0);
    applyStimulus(1, 60, 8'd12, 1'b0);
    waitDrain();

    $display("[TB] command on the wrapping edge");
    doReset();
    expectFrame(0, 20, 0);
    expectFrame(20, 20, 0);
    expectFrame(24, 24, 1);
    expectFrame(28, 28, 0);
    applyStimulus(1, 99, 8'd28, 1'b0);
    waitDrain();

    $display("[TB] enable drop mid-pulse and reset mid-pulse");
    doReset();
    expectFrame(0, 20, 0);
    expectFrame(20, 20, 0);
    expectFrame(20, 20, 1);
    expectFrame(0, 24, 1);
    expectFrame(0, 28, 1);
    expectFrame(30, 30, 0);
    waitAt(2, 5, ok);
    enable = 1'b0;
    applyStimulus(2, 10, 8'd30, 1'b0);
    waitAt(4, 50, ok);
    enable = 1'b1;
    waitDrain();
    waitAt(6, 10, ok);
    checkOutput("pwm_before_reset", int'(pwm_out), 1);
    reset = 1'b1;
    #1;
    checkOutput("pwm_on_async_reset", int'(pwm_out), 0);
    checkOutput("cur_width_on_async_reset", int'(cur_width), 20);
    checkOutput("busy_on_async_reset", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_ramp_ctrl.md
# servo_ramp_ctrl

Slew-limited position controller for one hobby servo on the forklift (lift or tilt axis). It accepts target pulse-width commands over a valid/ready handshake and steps the live pulse width toward the target by a bounded amount once per PWM frame. It also generates the frame-aligned PWM output itself, so width changes never produce runt or stretched pulses. It sits between the command/register logic and the servo output pin.

## Interface
- `FRAME_CYCLES`, default 1_000_000: clock cycles per PWM frame (20 ms at 50 MHz).
- `MIN_WIDTH`, default 50_000: minimum legal pulse width in cycles (1 ms).
- `MAX_WIDTH`, default 100_000: maximum legal pulse width in cycles (2 ms).
- `STEP`, default 500: maximum width change per frame, in cycles.
- `W`, default 20: width of all pulse-width and counter values; must hold `FRAME_CYCLES-1`.
- `clock_clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: controller can accept a command.
- `cmd_width`, in, W: requested pulse width in cycles.
- `enable`, in, 1: output enable level.
- `pwm_out`, out, 1: servo PWM pin.
- `cur_width`, out, W: pulse width in force for the current frame.
- `busy`, out, 1: `cur_width != target`.
- `err_range`, out, 1: one-cycle pulse when an accepted command was clamped.

## Operation
- Reset values:
  - `frame_cnt = 0`.
  - `cur_width = target = CENTER = (MIN_WIDTH+MAX_WIDTH)/2`.
  - `en_q = 0`, `pwm_out = 0`, `cmd_ready = 0`, `busy = 0`, `err_range = 0`.
- `cmd_ready` is 1 from the first clock edge after reset deassertion onward.
- Accept: a command is accepted on any edge where `cmd_valid && cmd_ready`.
  - `target <= clamp(cmd_width, MIN_WIDTH, MAX_WIDTH)`.
  - If clamping changed the value, `err_range` is 1 for the following cycle.
  - Later accepts overwrite `target`; there is no queue.
- Frame counter: `frame_cnt` counts `0..FRAME_CYCLES-1`, then wraps to 0.
- Frame boundary (the edge where `frame_cnt` wraps to 0):
  - The target used here is the newly accepted value if a command is accepted on the same edge, otherwise the stored `target`.
  - If `cur_width < target`: `cur_width <= min(cur_width+STEP, target)`.
  - If `cur_width > target`: `cur_width <= max(cur_width-STEP, target)`.
  - `en_q <= enable`.
- Arithmetic: step math uses W+1 bits so it cannot overflow or underflow.
- States, derived from `en_q` and `busy`:
  - OFF: `en_q = 0`.
  - HOLD: `en_q = 1`, `busy = 0`.
  - RAMP: `en_q = 1`, `busy = 1`.
  - Ramping continues while OFF, so the servo resumes at the ramped width.
- `pwm_out = en_q && (frame_cnt < cur_width)`, registered, aligned with `frame_cnt`.

## Timing
- `pwm_out` rises in the cycle where `frame_cnt == 0`.
- Each active frame drives exactly `cur_width` consecutive high cycles.
- Command-to-effect latency: the first frame boundary after acceptance, i.e. 1 to `FRAME_CYCLES` cycles.
- Full slew takes `ceil(|target-cur_width| / STEP)` frames.
- Enable changes mid-frame: ignored until the next boundary; an in-progress pulse always completes.
- Reset asserted mid-frame: `pwm_out` goes low immediately and all state returns to reset values.
- Out-of-range `cmd_width` values (0, above `MAX_WIDTH`, all ones): clamp, never wrap.

## Structure
- Shared package `servo_pkg`:
  - Default timing constants `FRAME_CYCLES`, `MIN_WIDTH`, `MAX_WIDTH`, `STEP`.
  - `CENTER` and `W`.
  - Clamp and step helper functions.
- One sub-module `servo_frame_timer`: the `frame_cnt` counter plus a one-cycle `frame_wrap` strobe.
- The top level holds command capture, the ramp register, `en_q` and the output compare.

## Test plan
All scenarios use small parameters: `FRAME_CYCLES=100`, `MIN_WIDTH=10`, `MAX_WIDTH=30`, `STEP=4`, `W=8`.
- Reset, `enable=1`, no command -> every frame has 20 high cycles starting at `frame_cnt==0`; `busy=0`.
- Accept `cmd_width=30` at `frame_cnt=50` -> frame widths 24, 28, 30, 30; `busy` falls at the boundary where 30 loads.
- Accept `cmd_width=200` -> `target=30`, one-cycle `err_range`. Accept `cmd_width=3` -> `target=10`, `err_range` pulses.
- Accept 30 then 12 within the same frame -> only 12 is used; widths step 16, 12.
- Accept `cmd_width=28` on the edge at `frame_cnt==99` -> the new frame already uses width 24.
- Drop `enable` at `frame_cnt=5` of a width-20 frame -> the pulse still lasts 20 cycles, then `pwm_out=0` from the next frame while `cur_width` keeps ramping. Assert `reset` mid-pulse -> `pwm_out=0` in the same cycle and `cur_width=20`.
